// File: rtl/pipeline_pkg.sv
// Shared pipeline types: control bundle, bubble encoding, register constants, interlock FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipeline_pkg;

  // Control bundle carried from Decode into Execute.
  // NoWrite marks flag-only ops (CMP/TST) whose result is not written back.
  // Cond sits in the top bits so a bubble reads 15'b1110_000...
  typedef struct packed {
    logic [3:0] Cond;
    logic [1:0] FlagWrite;
    logic       PCSrc;
    logic       RegWrite;
    logic       MemWrite;
    logic       Branch;
    logic       MemtoReg;
    logic       ALUSrc;
    logic [1:0] ALUControl;
    logic       NoWrite;
  } ctrl_t;

  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] REG_PC  = 4'hF;

  // A bubble is an always-executed no-op: nothing writes, nothing branches.
  localparam ctrl_t BUBBLE_CTRL = ctrl_t'({COND_AL, 11'b0});

  typedef enum logic {
    RUN       = 1'b0,
    INTERLOCK = 1'b1
  } ilk_state_t;

endpackage

// File: rtl/flopenrc.sv
// Register with enable and synchronous clear to a programmable value.
// Latency: one cycle from d to q.
// Backpressure: none; en holds the value, clr/reset override en.
//
// Ports: clk, reset (sync, active-high), en, clr, d[W], q[W].
module flopenrc #(
  parameter int           W       = 1,
  parameter logic [W-1:0] CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      q <= CLR_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use interlock, flush handling and a bubble counter.
// Latency: one cycle Decode -> Execute; StallD is combinational in the same cycle.
// Backpressure: StallD holds Fetch/Decode for one cycle while a bubble enters Execute.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   ValidD, CtrlD, RD1D, RD2D,
//   ExtImmD, RA1D, RA2D, WA3D       Decode-side instruction
//   FlushE                          kill the instruction entering Execute
//   CtrlE, RD1E, RD2E, ExtImmE,
//   RA1E, RA2E, WA3E, ValidE        registered Execute-side instruction
//   StallD                          stall PC and IF/ID (also used as StallF)
//   BubbleCount                     saturating count of interlock bubbles
module id_ex_stage
  import pipeline_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ValidD,
  input  ctrl_t             CtrlD,
  input  logic [DATA_W-1:0] RD1D,
  input  logic [DATA_W-1:0] RD2D,
  input  logic [DATA_W-1:0] ExtImmD,
  input  logic [3:0]        RA1D,
  input  logic [3:0]        RA2D,
  input  logic [3:0]        WA3D,
  input  logic              FlushE,
  output ctrl_t             CtrlE,
  output logic [DATA_W-1:0] RD1E,
  output logic [DATA_W-1:0] RD2E,
  output logic [DATA_W-1:0] ExtImmE,
  output logic [3:0]        RA1E,
  output logic [3:0]        RA2E,
  output logic [3:0]        WA3E,
  output logic              ValidE,
  output logic              StallD,
  output logic [CNT_W-1:0]  BubbleCount
);

  localparam int CW = $bits(ctrl_t) + 1;

  logic          hazard;
  logic          bubble;
  logic [CW-1:0] ctrl_q;
  ilk_state_t    state;

  // Load in Execute whose destination is read by Decode. A load into R15 is
  // a PC write handled by the flush path, so it never interlocks; that also
  // exempts any source equal to R15.
  assign hazard = ValidD && ValidE && CtrlE.MemtoReg && CtrlE.RegWrite &&
                  (WA3E != REG_PC) && ((RA1D == WA3E) || (RA2D == WA3E));

  assign StallD = hazard && !FlushE;

  // Flush, interlock and an empty Decode slot all insert the same bubble.
  assign bubble = FlushE || hazard || !ValidD;

  // Control group: ValidE rides in the LSB so it clears with the control bits.
  flopenrc #(
    .W       (CW),
    .CLR_VAL ({BUBBLE_CTRL, 1'b0})
  ) u_ctrl (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .clr   (bubble),
    .d     ({CtrlD, 1'b1}),
    .q     (ctrl_q)
  );

  assign CtrlE  = ctrl_t'(ctrl_q[CW-1:1]);
  assign ValidE = ctrl_q[0];

  flopenrc #(
    .W (3 * DATA_W)
  ) u_opnd (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .clr   (bubble),
    .d     ({RD1D, RD2D, ExtImmD}),
    .q     ({RD1E, RD2E, ExtImmE})
  );

  flopenrc #(
    .W (12)
  ) u_addr (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .clr   (bubble),
    .d     ({RA1D, RA2D, WA3D}),
    .q     ({RA1E, RA2E, WA3E})
  );

  // A flushed hazard is not a bubble the interlock caused, so it is not counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      BubbleCount <= '0;
    end else if (StallD && (BubbleCount != {CNT_W{1'b1}})) begin
      BubbleCount <= BubbleCount + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Interlock tracker: a stall always places a bubble in Execute, so the
  // cycle after a stall can never stall again.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:       if (StallD) state <= INTERLOCK;
        INTERLOCK: state <= RUN;
        default:   state <= RUN;
      endcase
    end
  end

  a_no_back_to_back_stall : assert property (
    @(posedge clk) disable iff (reset) !((state == INTERLOCK) && StallD)
  );

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage with a reference model and scoreboard queue.
// Latency: expected Execute state is pushed when Decode is driven, popped one edge later.
// Backpressure: StallD is compared combinationally every cycle against the model.
module tb_id_ex_stage;
  import pipeline_pkg::*;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 2;

  logic              clk;
  logic              reset;
  logic              ValidD;
  ctrl_t             CtrlD;
  logic [DATA_W-1:0] RD1D, RD2D, ExtImmD;
  logic [3:0]        RA1D, RA2D, WA3D;
  logic              FlushE;
  ctrl_t             CtrlE;
  logic [DATA_W-1:0] RD1E, RD2E, ExtImmE;
  logic [3:0]        RA1E, RA2E, WA3E;
  logic              ValidE;
  logic              StallD;
  logic [CNT_W-1:0]  BubbleCount;

  id_ex_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .ValidD(ValidD), .CtrlD(CtrlD),
    .RD1D(RD1D), .RD2D(RD2D), .ExtImmD(ExtImmD),
    .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D), .FlushE(FlushE),
    .CtrlE(CtrlE), .RD1E(RD1E), .RD2E(RD2E), .ExtImmE(ExtImmE),
    .RA1E(RA1E), .RA2E(RA2E), .WA3E(WA3E), .ValidE(ValidE),
    .StallD(StallD), .BubbleCount(BubbleCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    ctrl_t             ctrl;
    logic              v;
    logic [DATA_W-1:0] rd1, rd2, imm;
    logic [3:0]        ra1, ra2, wa3;
    logic [CNT_W-1:0]  cnt;
  } exp_t;

  exp_t sb[$];
  exp_t m;
  int   n_pass = 0;
  int   n_total = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic ctrl_t mk(input logic m2r, input logic rw, input logic [1:0] alu);
    ctrl_t c;
    c = '0;
    c.Cond = COND_AL;
    c.MemtoReg = m2r;
    c.RegWrite = rw;
    c.ALUSrc = m2r;
    c.ALUControl = alu;
    return c;
  endfunction

  task automatic drive(input logic v, input ctrl_t c, input logic [3:0] ra1, input logic [3:0] ra2,
                       input logic [3:0] wa3, input logic [31:0] rd1, input logic fl);
    ValidD = v; CtrlD = c; RA1D = ra1; RA2D = ra2; WA3D = wa3;
    RD1D = rd1; RD2D = rd1 ^ 32'h5A5A_0F0F; ExtImmD = {28'h0, wa3} + 32'h100; FlushE = fl;
  endtask

  // One clock of the reference model: check StallD now, predict Execute after the edge.
  task automatic step();
    logic haz;
    exp_t nx, got;
    #1;
    haz = ValidD && m.v && m.ctrl.MemtoReg && m.ctrl.RegWrite && (m.wa3 != 4'hF) &&
          ((RA1D == m.wa3) || (RA2D == m.wa3));
    check("stall", {63'b0, StallD}, {63'b0, haz && !FlushE});
    nx.ctrl = 15'b111_0000_0000_0000; nx.v = 1'b0;
    nx.rd1 = '0; nx.rd2 = '0; nx.imm = '0; nx.ra1 = '0; nx.ra2 = '0; nx.wa3 = '0;
    nx.cnt = m.cnt;
    if (reset) begin
      nx.cnt = '0;
    end else if (!FlushE && haz) begin
      if (m.cnt != 2'd3) nx.cnt = m.cnt + 2'd1;
    end else if (!FlushE && ValidD) begin
      nx.ctrl = CtrlD; nx.v = 1'b1; nx.rd1 = RD1D; nx.rd2 = RD2D; nx.imm = ExtImmD;
      nx.ra1 = RA1D; nx.ra2 = RA2D; nx.wa3 = WA3D;
    end
    sb.push_back(nx);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check("ctrl",  {49'b0, CtrlE},   {49'b0, got.ctrl});
    check("valid", {63'b0, ValidE},  {63'b0, got.v});
    check("rd1",   {32'b0, RD1E},    {32'b0, got.rd1});
    check("rd2",   {32'b0, RD2E},    {32'b0, got.rd2});
    check("imm",   {32'b0, ExtImmE}, {32'b0, got.imm});
    check("addr",  {52'b0, RA1E, RA2E, WA3E}, {52'b0, got.ra1, got.ra2, got.wa3});
    check("count", {62'b0, BubbleCount}, {62'b0, got.cnt});
    m = got;
  endtask

  logic [CNT_W-1:0] sat_exp [5];

  initial begin
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    m.ctrl = 15'b111_0000_0000_0000; m.v = 1'b0; m.rd1 = '0; m.rd2 = '0; m.imm = '0;
    m.ra1 = '0; m.ra2 = '0; m.wa3 = '0; m.cnt = '0;

    // Reset with random Decode inputs; first edge establishes a known state.
    reset = 1'b1;
    drive(1'b1, ctrl_t'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), $urandom, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b1, ctrl_t'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), $urandom, 1'b0);
    step();
    check("rst_ctrl", {49'b0, CtrlE}, {49'b0, 15'b111_0000_0000_0000});
    check("rst_stall", {63'b0, StallD}, 64'd0);
    reset = 1'b0;

    // Pass-through.
    drive(1'b1, mk(1'b0, 1'b1, 2'b00), 4'd1, 4'd2, 4'd3, 32'hDEADBEEF, 1'b0);
    step();
    check("pt_rd1", {32'b0, RD1E}, {32'b0, 32'hDEADBEEF});
    check("pt_wa3", {60'b0, WA3E}, 64'd3);

    // Load-use on RA2: LDR R4 then a reader of R4.
    drive(1'b1, mk(1'b1, 1'b1, 2'b00), 4'd0, 4'd0, 4'd4, 32'h1000, 1'b0);
    step();
    drive(1'b1, mk(1'b0, 1'b1, 2'b01), 4'd5, 4'd4, 4'd7, 32'h2222, 1'b0);
    #1;
    check("lu_stall", {63'b0, StallD}, 64'd1);
    step();
    check("lu_cnt", {62'b0, BubbleCount}, 64'd1);
    check("lu_unstall", {63'b0, StallD}, 64'd0);
    step();
    check("lu_enter", {60'b0, WA3E}, 64'd7);

    // Flush beats hazard.
    drive(1'b1, mk(1'b1, 1'b1, 2'b00), 4'd0, 4'd0, 4'd4, 32'h1000, 1'b0);
    step();
    drive(1'b1, mk(1'b0, 1'b1, 2'b01), 4'd4, 4'd1, 4'd8, 32'h3333, 1'b1);
    step();
    check("fl_cnt", {62'b0, BubbleCount}, 64'd1);

    // Idle Decode slot.
    drive(1'b0, mk(1'b0, 1'b1, 2'b10), 4'd1, 4'd1, 4'd1, 32'h4444, 1'b0);
    step();

    // PC exemptions.
    drive(1'b1, mk(1'b1, 1'b1, 2'b00), 4'd0, 4'd0, 4'd4, 32'h5000, 1'b0);
    step();
    drive(1'b1, mk(1'b0, 1'b1, 2'b00), 4'd15, 4'd0, 4'd9, 32'h5555, 1'b0);
    step();
    drive(1'b1, mk(1'b1, 1'b1, 2'b00), 4'd0, 4'd0, 4'd15, 32'h6000, 1'b0);
    step();
    drive(1'b1, mk(1'b0, 1'b1, 2'b00), 4'd15, 4'd15, 4'd9, 32'h6666, 1'b0);
    step();

    // Reset during an interlock.
    drive(1'b1, mk(1'b1, 1'b1, 2'b00), 4'd0, 4'd0, 4'd6, 32'h7000, 1'b0);
    step();
    drive(1'b1, mk(1'b0, 1'b1, 2'b00), 4'd6, 4'd0, 4'd2, 32'h7777, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_mid_cnt", {62'b0, BubbleCount}, 64'd0);

    // Saturation: five load-use pairs.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, mk(1'b1, 1'b1, 2'b00), 4'd0, 4'd0, 4'd6, 32'h8000 + i, 1'b0);
      step();
      drive(1'b1, mk(1'b0, 1'b1, 2'b00), 4'd6, 4'd1, 4'd2, 32'h9000 + i, 1'b0);
      step();
      check("sat", {62'b0, BubbleCount}, {62'b0, sat_exp[i]});
      step();
    end

    // Random traffic with dense register collisions.
    for (int i = 0; i < 60; i++) begin
      drive(($urandom_range(0, 7) != 0),
            mk($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, 2'($urandom)),
            ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(3, 6)),
            4'($urandom_range(3, 6)),
            ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(3, 6)),
            $urandom, ($urandom_range(0, 7) == 0));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
